// File: rtl/ram_pkg.sv
// ram_pkg -- shared definitions for the ram_array block.
//
// Contents:
//   ram_state_t : controller states (CLEAR sweeps zeros through the array,
//                 IDLE serves read/write requests).
//   PAR_W       : parity bits stored alongside each word (1 when
//                 RAM_PARITY_EN is defined, 0 otherwise).
//   even_par    : even-parity helper for words up to 64 bits.
//
// Configuration macro: RAM_PARITY_EN
package ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } ram_state_t;

`ifdef RAM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    // Even parity: the stored bit makes the total count of ones even,
    // which is simply the XOR reduction of the data.
    function automatic logic even_par(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ram_core.sv
// ram_core -- word storage for ram_array.
//
// One synchronous write port and one registered read port. The array
// itself has no reset; only the read output register is reset so the
// read result starts at zero.
//
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset (read register only)
//   we     : write enable, mem[waddr] <= wdata at the edge
//   waddr  : write address
//   wdata  : write word (data plus optional parity bit)
//   re     : read enable, rword <= mem[raddr] at the edge
//   raddr  : read address
//   rword  : registered read word, holds when re is low
module ram_core
    import ram_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rword
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rword <= '0;
        end else if (re) begin
            rword <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_array.sv
// ram_array -- small single-port RAM with a self-clearing controller.
//
// After reset (and on every clear_req accepted in IDLE) the controller
// spends exactly DEPTH cycles writing zeros to every word, then serves
// one read or write per cycle. Reads have one cycle of latency.
//
// Handshake: a request transfers on a rising edge where req_valid && ready.
// ready is combinational and low while clearing or while clear_req is
// high; requests seen with ready low are dropped, never queued.
//
// Ports:
//   clock      : rising-edge clock
//   reset      : asynchronous active-low reset
//   clear_req  : request full-array zero fill (honoured in IDLE only)
//   req_valid  : access request
//   req_write  : 1 = write, 0 = read
//   req_addr   : access address
//   req_wdata  : write data
//   ready      : request accepted when req_valid && ready
//   busy       : clear sequence in progress
//   rd_valid   : rd_data carries a new read result this cycle
//   rd_data    : read result, holds its last value otherwise
//   parity_err : stored parity disagrees with the word being returned
//
// Configuration macro: RAM_PARITY_EN (adds one even-parity bit per word;
// without it parity_err is tied low and no parity storage exists).
module ram_array
    import ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_req,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              ready,
    output logic              busy,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              parity_err
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int STORE_W = DATA_W + PAR_W;

    ram_state_t        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              rd_valid_q;

    logic               accept;
    logic               core_we;
    logic               core_re;
    logic [ADDR_W-1:0]  core_waddr;
    logic [DATA_W-1:0]  wr_data;
    logic [STORE_W-1:0] core_wdata;
    logic [STORE_W-1:0] core_rword;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rd_valid_q <= core_re;
        end
    end

    // ------------------------------------------------------------------
    // Next state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        ready      = (state_q == IDLE) && !clear_req;
        accept     = req_valid && ready;
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        core_we    = 1'b0;
        core_re    = 1'b0;
        core_waddr = req_addr;
        wr_data    = req_wdata;

        case (state_q)
            CLEAR: begin
                // One word zeroed per cycle; the last word hands over to IDLE
                // and the counter returns to 0 for the next sweep.
                core_we    = 1'b1;
                core_waddr = clr_cnt_q;
                wr_data    = '0;
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d   = IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                end else if (accept) begin
                    core_we = req_write;
                    core_re = !req_write;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

`ifdef RAM_PARITY_EN
    assign core_wdata = {even_par(64'(wr_data)), wr_data};
    assign parity_err = rd_valid_q &&
                        (core_rword[DATA_W] != even_par(64'(core_rword[DATA_W-1:0])));
`else
    assign core_wdata = wr_data;
    assign parity_err = 1'b0;
`endif

    assign busy     = (state_q == CLEAR);
    assign rd_valid = rd_valid_q;
    assign rd_data  = core_rword[DATA_W-1:0];

    ram_core #(
        .WORD_W (STORE_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clock (clock),
        .reset (reset),
        .we    (core_we),
        .waddr (core_waddr),
        .wdata (core_wdata),
        .re    (core_re),
        .raddr (req_addr),
        .rword (core_rword)
    );

endmodule

// File: tb/tb_ram_array.sv
// tb_ram_array -- self-checking bench for ram_array (DATA_W = 8, ADDR_W = 2).
//
// Inputs change on the falling edge; outputs are compared on the falling
// edge against a word-level model (array contents, remaining clear cycles,
// queue of expected read results).
module tb_ram_array;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    // ------------------------------------------------------------------
    // Clock / reset and DUT
    // ------------------------------------------------------------------
    logic              clock     = 1'b0;
    logic              reset     = 1'b0;
    logic              clear_req = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr  = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              ready;
    logic              busy;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              parity_err;

    always #5 clock = ~clock;

    ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .clear_req  (clear_req),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .ready      (ready),
        .busy       (busy),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .parity_err (parity_err)
    );

    // ------------------------------------------------------------------
    // Reference model and scoreboard state
    // ------------------------------------------------------------------
    int                checks = 0;
    int                errors = 0;
    logic [DATA_W-1:0] m_mem [DEPTH];
    logic              m_bad [DEPTH];
    int                clear_left = DEPTH;
    logic              exp_rv     = 1'b0;
    logic              exp_perr   = 1'b0;
    logic [DATA_W-1:0] last_rd    = '0;
    logic [DATA_W-1:0] exp_q[$];
    logic              chk_en     = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drive one cycle of inputs (called on a falling edge), check the
    // combinational ready, then advance the model by what the coming
    // rising edge must do. Returns on the next falling edge.
    task automatic cycle(input logic cr, input logic v, input logic w,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        clear_req = cr;
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        #1;
        chk("ready", ready, (clear_left == 0) && !cr);
        exp_rv   = 1'b0;
        exp_perr = 1'b0;
        if (clear_left > 0) begin
            m_mem[DEPTH - clear_left] = '0;
            m_bad[DEPTH - clear_left] = 1'b0;
            clear_left--;
        end else if (cr) begin
            clear_left = DEPTH;
        end else if (v) begin
            if (w) begin
                m_mem[a] = d;
                m_bad[a] = 1'b0;
            end else begin
                exp_q.push_back(m_mem[a]);
                exp_rv   = 1'b1;
                exp_perr = m_bad[a];
            end
        end
        @(negedge clock);
    endtask

    // ------------------------------------------------------------------
    // Compare process
    // ------------------------------------------------------------------
    always @(negedge clock) begin
        if (chk_en) begin
            chk("busy", busy, clear_left > 0);
            chk("rd_valid", rd_valid, exp_rv);
            chk("parity_err", parity_err, exp_rv && exp_perr);
            if (exp_rv) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL exp_q actual=empty required=entry");
                end else begin
                    last_rd = exp_q.pop_front();
                end
            end
            chk("rd_data", rd_data, last_rd);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int cnt;
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_bad[i] = 1'b0;
        end

        // Held in reset
        repeat (3) @(negedge clock);
        chk("rst_busy", busy, 1);
        chk("rst_ready", ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_parity_err", parity_err, 0);

        // Release: the clear sweep must last exactly DEPTH cycles
        reset      = 1'b1;
        clear_left = DEPTH;
        chk_en     = 1'b1;
        cnt = 0;
        while (busy && cnt < 10) begin
            cycle(1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
            cnt++;
        end
        chk("post_reset_busy_cycles", cnt, 4);

        // Every word reads back zero
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 2'(i), 8'h00);
            chk("zero_read_valid", rd_valid, 1);
            chk("zero_read_data", rd_data, 8'h00);
        end

        // Write then immediate read of the same address
        cycle(1'b0, 1'b1, 1'b1, 2'd2, 8'hA5);
        chk("write_no_rd_valid", rd_valid, 0);
        cycle(1'b0, 1'b1, 1'b0, 2'd2, 8'h00);
        chk("raw_read_valid", rd_valid, 1);
        chk("raw_read_data", rd_data, 8'hA5);
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        chk("idle_rd_valid", rd_valid, 0);
        chk("idle_rd_hold", rd_data, 8'hA5);

        // Clear request with a write held alongside: write dropped, clear
        // not restarted by a second clear_req in the middle
        cycle(1'b0, 1'b1, 1'b1, 2'd1, 8'h3C);
        cycle(1'b1, 1'b1, 1'b1, 2'd1, 8'hFF);
        cnt = 0;
        while (busy && cnt < 10) begin
            cycle(cnt == 1, 1'b1, 1'b1, 2'd1, 8'hFF);
            cnt++;
        end
        chk("clear_busy_cycles", cnt, 4);
        cycle(1'b0, 1'b1, 1'b0, 2'd1, 8'h00);
        chk("read_after_clear", rd_data, 8'h00);

        // Back-to-back writes then reads over the whole address range
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 2'(i), 8'(8'h11 * (i + 1)));
        end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 2'(i), 8'h00);
            chk("wrap_read", rd_data, 8'(8'h11 * (i + 1)));
        end

`ifdef RAM_PARITY_EN
        // Corrupt one stored data bit of address 3 behind the parity bit
        dut.u_core.mem[3][0] = ~dut.u_core.mem[3][0];
        m_mem[3][0] = ~m_mem[3][0];
        m_bad[3]    = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 2'd3, 8'h00);
        chk("parity_err_flag", parity_err, 1);
        cycle(1'b0, 1'b1, 1'b1, 2'd3, 8'h44);
        chk("parity_err_clears", parity_err, 0);
`endif

        // Reset while a read result is on the outputs: drops immediately
        cycle(1'b0, 1'b1, 1'b0, 2'd3, 8'h00);
        chk_en    = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 2'd2;
        @(posedge clock);
        #1;
        chk("pre_reset_rd_valid", rd_valid, 1);
        reset = 1'b0;
        #1;
        chk("async_rst_rd_valid", rd_valid, 0);
        chk("async_rst_busy", busy, 1);
        chk("async_rst_ready", ready, 0);
        chk("async_rst_rd_data", rd_data, 0);
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset      = 1'b1;
        clear_left = DEPTH;
        exp_q.delete();
        exp_rv     = 1'b0;
        exp_perr   = 1'b0;
        last_rd    = '0;
        chk_en     = 1'b1;
        cnt = 0;
        while (busy && cnt < 10) begin
            cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
            cnt++;
        end
        chk("rereset_busy_cycles", cnt, 4);

        // Randomized traffic
        repeat (400) begin
            cycle($urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 7,
                  1'($urandom_range(0, 1)),
                  2'($urandom_range(0, DEPTH - 1)),
                  8'($urandom_range(0, 255)));
        end
        repeat (DEPTH + 2) cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
